// File: rtl/ring_johnson_monitor.sv
// ring_johnson_monitor
// Checks a ring counter and a Johnson counter that share clk/rst. Each code is
// decoded to a phase index, each step is compared against the legal successor
// of the previous sample, and the results are reported as lock status,
// per-cycle error pulses, a sticky flag and a saturating error count.
// Every output is registered and reflects the sample taken at the previous edge.
module ring_johnson_monitor #(
    parameter int N           = 2,
    parameter int LOCK_CYC    = 4,
    parameter int CNT_W       = 8,
    parameter int CHECK_START = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            doutr,
    input  logic [N-1:0]            doutj,
    input  logic                    clr_err,
    output logic [$clog2(N)-1:0]    ring_phase,
    output logic [$clog2(2*N)-1:0]  john_phase,
    output logic                    locked,
    output logic                    ring_err,
    output logic                    john_err,
    output logic                    start_err,
    output logic                    err_sticky,
    output logic [CNT_W-1:0]        err_count
);

    localparam int RP_W = $clog2(N);
    localparam int JP_W = $clog2(2 * N);
    localparam int GC_W = $clog2(LOCK_CYC + 1);

    localparam logic [N-1:0]    ONE_N     = N'(1);
    localparam logic [N-1:0]    RING_INIT = N'(1);
    localparam logic [N-1:0]    JOHN_INIT = '0;
    localparam logic [GC_W-1:0] GC_ONE    = GC_W'(1);
    localparam logic [GC_W-1:0] GC_LOCK   = GC_W'(LOCK_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Legal successor of a ring code: rotate left, MSB wraps into LSB.
    function automatic logic [N-1:0] ring_next(input logic [N-1:0] r);
        return {r[N-2:0], r[N-1]};
    endfunction

    // Legal successor of a Johnson code: shift left, inverted MSB into LSB.
    function automatic logic [N-1:0] john_next(input logic [N-1:0] j);
        return {j[N-2:0], ~j[N-1]};
    endfunction

    function automatic int unsigned popcnt(input logic [N-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

    function automatic logic ring_legal(input logic [N-1:0] r);
        return popcnt(r) == 1;
    endfunction

    // Johnson codes are exactly the thermometer patterns 0..01..1 and 1..10..0;
    // x & (x+1) == 0 detects the first form, applied to ~x it detects the second.
    function automatic logic john_legal(input logic [N-1:0] j);
        logic [N-1:0] inv;
        inv = ~j;
        return ((j & (j + ONE_N)) == '0) || ((inv & (inv + ONE_N)) == '0);
    endfunction

    function automatic logic [RP_W-1:0] ring_idx(input logic [N-1:0] r);
        logic [RP_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) idx = RP_W'(i);
        end
        return idx;
    endfunction

    // Ones fill from the LSB during the first half period, then drain.
    function automatic logic [JP_W-1:0] john_idx(input logic [N-1:0] j);
        int unsigned pc;
        pc = popcnt(j);
        if (j[N-1]) return JP_W'(2 * N - pc);
        return JP_W'(pc);
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c == '1) return c;
        return c + CNT_ONE;
    endfunction

    state_t          state, state_nxt;
    logic [GC_W-1:0] good_cnt, good_cnt_nxt, good_cnt_inc;
    logic            prev_vld, prev_vld_nxt;
    logic [N-1:0]    prev_r, prev_r_nxt;
    logic [N-1:0]    prev_j, prev_j_nxt;
    logic            first_flag, first_nxt;

    logic            r_legal, j_legal;
    logic            r_match, j_match;
    logic            ring_err_nxt, john_err_nxt, start_err_nxt;
    logic            any_err;
    logic [RP_W-1:0] ring_phase_nxt;
    logic [JP_W-1:0] john_phase_nxt;

    assign r_legal      = ring_legal(doutr);
    assign j_legal      = john_legal(doutj);
    assign r_match      = prev_vld && (doutr == ring_next(prev_r));
    assign j_match      = prev_vld && (doutj == john_next(prev_j));
    assign good_cnt_inc = good_cnt + GC_ONE;
    assign any_err      = ring_err_nxt | john_err_nxt | start_err_nxt;

    // Phase decode of the current sample; illegal codes decode to phase 0.
    always_comb begin
        ring_phase_nxt = '0;
        john_phase_nxt = '0;
        if (r_legal) ring_phase_nxt = ring_idx(doutr);
        if (j_legal) john_phase_nxt = john_idx(doutj);
    end

    // Next-state logic: acquire a legal seed, track successors, hold lock.
    always_comb begin
        state_nxt     = state;
        good_cnt_nxt  = good_cnt;
        prev_vld_nxt  = prev_vld;
        prev_r_nxt    = prev_r;
        prev_j_nxt    = prev_j;
        first_nxt     = first_flag;
        ring_err_nxt  = 1'b0;
        john_err_nxt  = 1'b0;
        start_err_nxt = 1'b0;

        case (state)
            ACQ: begin
                first_nxt = 1'b0;
                if ((CHECK_START != 0) && first_flag &&
                    !((doutr == RING_INIT) && (doutj == JOHN_INIT))) begin
                    start_err_nxt = 1'b1;
                end
                if (r_legal && j_legal) begin
                    prev_r_nxt   = doutr;
                    prev_j_nxt   = doutj;
                    prev_vld_nxt = 1'b1;
                    good_cnt_nxt = '0;
                    state_nxt    = TRACK;
                end else begin
                    ring_err_nxt = !r_legal;
                    john_err_nxt = !j_legal;
                end
            end

            TRACK, LOCKED: begin
                if (r_match && j_match) begin
                    prev_r_nxt = doutr;
                    prev_j_nxt = doutj;
                    if (state == TRACK) begin
                        good_cnt_nxt = good_cnt_inc;
                        if (good_cnt_inc == GC_LOCK) state_nxt = LOCKED;
                    end
                end else begin
                    ring_err_nxt = !r_match;
                    john_err_nxt = !j_match;
                    if (r_legal && j_legal) begin
                        // Both codes are usable: restart tracking from here.
                        prev_r_nxt   = doutr;
                        prev_j_nxt   = doutj;
                        good_cnt_nxt = '0;
                        state_nxt    = TRACK;
                    end else begin
                        prev_vld_nxt = 1'b0;
                        good_cnt_nxt = '0;
                        state_nxt    = ACQ;
                    end
                end
            end

            default: begin
                prev_vld_nxt = 1'b0;
                good_cnt_nxt = '0;
                state_nxt    = ACQ;
            end
        endcase
    end

    // FSM control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACQ;
            good_cnt   <= '0;
            prev_vld   <= 1'b0;
            first_flag <= 1'b1;
        end else begin
            state      <= state_nxt;
            good_cnt   <= good_cnt_nxt;
            prev_vld   <= prev_vld_nxt;
            first_flag <= first_nxt;
        end
    end

    // Previous-sample data; meaningful only while prev_vld is set.
    always_ff @(posedge clk) begin
        prev_r <= prev_r_nxt;
        prev_j <= prev_j_nxt;
    end

    // Registered phases, lock flag and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_phase <= '0;
            john_phase <= '0;
            locked     <= 1'b0;
            ring_err   <= 1'b0;
            john_err   <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            ring_phase <= ring_phase_nxt;
            john_phase <= john_phase_nxt;
            locked     <= (state_nxt == LOCKED);
            ring_err   <= ring_err_nxt;
            john_err   <= john_err_nxt;
            start_err  <= start_err_nxt;
        end
    end

    // Sticky flag and per-cycle saturating count; a same-cycle error beats clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (clr_err) begin
            err_sticky <= any_err;
            err_count  <= any_err ? CNT_ONE : '0;
        end else begin
            err_sticky <= err_sticky | any_err;
            if (any_err) err_count <= sat_inc(err_count);
        end
    end

endmodule
